efuse_macro_emu: RTL and testbench

EFUSE_MACRO_EMU -- requirements
Module: efuse_macro_emu

---
 rtl/efuse_macro_emu.sv | 159 +++++++++++++++
 tb/tb_efuse_macro_emu.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/efuse_macro_emu.sv
// Behavioural emulation of a 256-bit eFuse macro as seen by its controller.
// Reads return one byte RD_LAT cycles after the sampled aen rising edge.
// Program pulses set a single bit on the aen falling edge, but only if the
// pulse lasted at least TPGM_MIN cycles. Bits only ever go 0->1 outside reset.
// Protocol misuse is recorded in sticky error flags {addr_chg, short_pgm, overlap}.
module efuse_macro_emu #(
  parameter int           RD_LAT     = 2,
  parameter int           TPGM_MIN   = 4,
  parameter logic [255:0] INIT_VALUE = 256'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       efuse_pgmen_i,
  input  logic       efuse_rden_i,
  input  logic       efuse_aen_i,
  input  logic [7:0] efuse_addr_i,
  output logic [7:0] efuse_rdata_o,
  output logic [8:0] prog_cnt_o,
  output logic [2:0] err_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {IDLE, READ, PGM} state_t;

  localparam logic [3:0] LAT_LAST = 4'(RD_LAT - 1);
  localparam logic [9:0] PGM_MIN  = 10'(TPGM_MIN);
  localparam logic [9:0] PLS_MAX  = 10'd1023;

  state_t       state, state_nx;
  logic [255:0] fuse;
  logic         aen_d;
  logic         rden_d;
  // Set when aen was already high at the last reset edge, so that a strobe
  // held across reset is not mistaken for a fresh rising edge.
  logic         rise_blk;
  logic [3:0]   lat_cnt;
  logic [4:0]   rd_byte;
  logic [7:0]   pgm_addr;
  logic [9:0]   pls_cnt;

  logic rise, fall, rd_req, pgm_req, both_req;
  logic rd_start, rd_done, pgm_start, pgm_end, pgm_ok;
  logic set_ovl, set_short, set_chg;

  assign rise     = efuse_aen_i & ~aen_d & ~rise_blk;
  assign fall     = ~efuse_aen_i & aen_d;
  assign rd_req   = efuse_rden_i & ~efuse_pgmen_i;
  assign pgm_req  = efuse_pgmen_i & ~efuse_rden_i;
  assign both_req = efuse_pgmen_i & efuse_rden_i;
  assign busy_o   = (state == READ) || (state == PGM);

  // Next-state decode and per-cycle action strobes.
  always_comb begin
    state_nx  = state;
    rd_start  = 1'b0;
    rd_done   = 1'b0;
    pgm_start = 1'b0;
    pgm_end   = 1'b0;
    pgm_ok    = 1'b0;
    set_ovl   = 1'b0;
    set_short = 1'b0;
    set_chg   = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          if (rd_req) begin
            rd_start = 1'b1;
            state_nx = READ;
          end else if (pgm_req) begin
            pgm_start = 1'b1;
            state_nx  = PGM;
          end else if (both_req) begin
            set_ovl = 1'b1;
          end
        end
      end
      READ: begin
        // A fresh read strobe wins over completing the current one.
        if (rise && rd_req) begin
          rd_start = 1'b1;
        end else begin
          if (rise && both_req) set_ovl = 1'b1;
          if (lat_cnt == LAT_LAST) begin
            rd_done  = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      PGM: begin
        if (fall) begin
          pgm_end   = 1'b1;
          pgm_ok    = (pls_cnt >= PGM_MIN);
          set_short = (pls_cnt < PGM_MIN);
          state_nx  = IDLE;
        end else if (efuse_aen_i) begin
          if (efuse_addr_i != pgm_addr)   set_chg = 1'b1;
          if (efuse_rden_i && !rden_d)    set_ovl = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register, edge detectors and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      aen_d    <= 1'b0;
      rden_d   <= 1'b0;
      rise_blk <= efuse_aen_i;
      err_o    <= 3'b000;
    end else begin
      state    <= state_nx;
      aen_d    <= efuse_aen_i;
      rden_d   <= efuse_rden_i;
      rise_blk <= 1'b0;
      err_o    <= err_o | {set_chg, set_short, set_ovl};
    end
  end

  // Read path: latch byte index, count latency, load the output byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt       <= 4'd0;
      rd_byte       <= 5'd0;
      efuse_rdata_o <= 8'h00;
    end else begin
      if (rd_start) begin
        rd_byte <= efuse_addr_i[4:0];
        lat_cnt <= 4'd0;
      end else if (state == READ) begin
        lat_cnt <= lat_cnt + 4'd1;
      end
      if (rd_done) efuse_rdata_o <= fuse[{rd_byte, 3'b000} +: 8];
    end
  end

  // Program path: pulse width counter, one-way bit set, newly-set counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      fuse       <= INIT_VALUE;
      pgm_addr   <= 8'd0;
      pls_cnt    <= 10'd0;
      prog_cnt_o <= 9'd0;
    end else begin
      if (pgm_start) begin
        pgm_addr <= efuse_addr_i;
        pls_cnt  <= 10'd1;
      end else if (state == PGM && efuse_aen_i && pls_cnt != PLS_MAX) begin
        pls_cnt <= pls_cnt + 10'd1;
      end
      if (pgm_end && pgm_ok) begin
        fuse[pgm_addr] <= 1'b1;
        if (!fuse[pgm_addr]) prog_cnt_o <= prog_cnt_o + 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_efuse_macro_emu.sv
// Directed bench for efuse_macro_emu: transaction-level fuse model plus a
// per-cycle compare of rdata / prog_cnt / err, and literal spot checks.
module tb_efuse_macro_emu;
  localparam int           RD_LAT = 2;
  localparam int           TPGM   = 4;
  localparam logic [255:0] INIT   = 256'h0;

  logic       clk = 1'b0;
  logic       rst, pgmen, rden, aen;
  logic [7:0] addr, rdata;
  logic [8:0] prog_cnt;
  logic [2:0] err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [255:0] m_fuse;
  logic [7:0]   m_rdata;
  int           m_prog;
  logic [2:0]   m_err;
  bit           model_on = 1'b0;

  efuse_macro_emu #(.RD_LAT(RD_LAT), .TPGM_MIN(TPGM), .INIT_VALUE(INIT)) dut (
    .clk(clk), .rst(rst), .efuse_pgmen_i(pgmen), .efuse_rden_i(rden),
    .efuse_aen_i(aen), .efuse_addr_i(addr), .efuse_rdata_o(rdata),
    .prog_cnt_o(prog_cnt), .err_o(err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_fuse  = INIT;
    m_rdata = 8'h00;
    m_prog  = 0;
    m_err   = 3'b000;
  endtask

  function automatic logic [7:0] mbyte(input logic [4:0] k);
    return m_fuse[8*k +: 8];
  endfunction

  // Model-vs-DUT compare, away from the active edge.
  always @(negedge clk) begin
    if (model_on) begin
      chk("rdata", 32'(rdata), 32'(m_rdata));
      chk("prog_cnt", 32'(prog_cnt), 32'(m_prog));
      chk("err", 32'(err), 32'(m_err));
    end
  end

  // Single-cycle aen read strobe; busy must cover exactly RD_LAT cycles.
  task automatic rd(input logic [7:0] a);
    aen = 1'b1; rden = 1'b1; addr = a;
    tick();
    chk("rd_busy_first", 32'(busy), 32'd1);
    aen = 1'b0; rden = 1'b0;
    for (int i = 1; i < RD_LAT; i++) begin
      tick();
      chk("rd_busy_wait", 32'(busy), 32'd1);
    end
    tick();
    m_rdata = mbyte(a[4:0]);
    chk("rd_busy_done", 32'(busy), 32'd0);
  endtask

  // n-cycle program pulse; optionally move addr at pulse cycle chg_at.
  task automatic pgm(input logic [7:0] a, input int n, input int chg_at, input logic [7:0] a2);
    aen = 1'b1; pgmen = 1'b1; addr = a;
    tick();
    chk("pgm_busy", 32'(busy), 32'd1);
    for (int i = 1; i < n; i++) begin
      if (i == chg_at) addr = a2;
      tick();
      if (i == chg_at) m_err[2] = 1'b1;
    end
    aen = 1'b0; pgmen = 1'b0; addr = a;
    tick();
    if (n >= TPGM) begin
      if (!m_fuse[a]) m_prog++;
      m_fuse[a] = 1'b1;
    end else begin
      m_err[1] = 1'b1;
    end
    chk("pgm_busy_end", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; pgmen = 1'b0; rden = 1'b0; aen = 1'b0; addr = 8'h00;
    tick(); tick();
    model_reset();
    model_on = 1'b1;
    rst = 1'b0;
    chk("reset_rdata", 32'(rdata), 32'h00);
    chk("reset_prog", 32'(prog_cnt), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);

    // Read of an unprogrammed byte
    rd(8'h05);
    chk("rd5_blank", 32'(rdata), 32'h00);

    // Program bit 0x2B (byte 5, bit 3), then read it back
    pgm(8'h2B, 4, -1, 8'h00);
    rd(8'h05);
    chk("rd5_prog", 32'(rdata), 32'h08);
    chk("prog_one", 32'(prog_cnt), 32'd1);

    // Re-program the same bit: no new count, no error
    pgm(8'h2B, 6, -1, 8'h00);
    chk("prog_again", 32'(prog_cnt), 32'd1);
    chk("err_none", 32'(err), 32'd0);

    // Short pulse on bit 0
    pgm(8'h00, 3, -1, 8'h00);
    chk("err_short", 32'(err), 32'b010);
    rd(8'h00);
    chk("rd0_short", 32'(rdata), 32'h00);

    // Rise with both enables set
    aen = 1'b1; rden = 1'b1; pgmen = 1'b1; addr = 8'h07;
    tick();
    m_err[0] = 1'b1;
    chk("ovl_busy", 32'(busy), 32'd0);
    aen = 1'b0; rden = 1'b0; pgmen = 1'b0;
    tick();
    chk("err_ovl", 32'(err), 32'b011);

    // Address moved mid-pulse: latched bit 0x10 still programmed
    pgm(8'h10, 5, 1, 8'h11);
    chk("err_chg", 32'(err), 32'b111);
    chk("prog_two", 32'(prog_cnt), 32'd2);
    rd(8'h02);
    chk("rd2", 32'(rdata), 32'h01);

    // Restarted read: first (byte 0) discarded, second (byte 5) delivered
    aen = 1'b1; rden = 1'b1; addr = 8'h00;
    tick();
    aen = 1'b0;
    tick();
    aen = 1'b1; addr = 8'h05;
    tick();
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_hold", 32'(rdata), 32'h01);
    aen = 1'b0; rden = 1'b0;
    tick();
    tick();
    m_rdata = mbyte(5'd5);
    chk("restart_data", 32'(rdata), 32'h08);

    // Reset two cycles into a long pulse on bit 0xFF; aen stays high across reset
    aen = 1'b1; pgmen = 1'b1; addr = 8'hFF;
    tick(); tick();
    rst = 1'b1;
    tick();
    model_reset();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    aen = 1'b0; pgmen = 1'b0;
    tick();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_prog", 32'(prog_cnt), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_rdata", 32'(rdata), 32'h00);
    rd(8'h1F);
    chk("rd31_abort", 32'(rdata), 32'h00);
    rd(8'h05);
    chk("rd5_cleared", 32'(rdata), 32'h00);

    // Programming works again after reset
    pgm(8'hFF, 4, -1, 8'h00);
    rd(8'h1F);
    chk("rd31_prog", 32'(rdata), 32'h80);
    chk("prog_after_rst", 32'(prog_cnt), 32'd1);

    tick(); tick();
    model_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
